// File: rtl/ram_arb2.sv
// Round-robin arbiter sharing one single-port RAM between two clients.
// Each winning request gets one registered ACCESS cycle on the RAM port, followed by a one-cycle ack.
module ram_arb2 #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_rw,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    logic   last;
    logic   elig0, elig1, win0, win1;

    // The client whose access ends at this edge has its ack issued here, so its held req does
    // not count; this lets the other client follow immediately while a lone client waits a cycle.
    always_comb begin
        elig0 = req0 && !gnt0;
        elig1 = req1 && !gnt1;
        win0  = elig0 && (!elig1 || last);
        win1  = elig1 && (!elig0 || !last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_rw    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack0 <= gnt0;
            ack1 <= gnt1;
            if (gnt0 && !ram_rw) rdata0 <= ram_rdata;
            if (gnt1 && !ram_rw) rdata1 <= ram_rdata;

            if (win0) begin
                state     <= ACCESS;
                last      <= 1'b0;
                gnt0      <= 1'b1;
                gnt1      <= 1'b0;
                busy      <= 1'b1;
                ram_addr  <= addr0;
                ram_wdata <= wdata0;
                ram_rw    <= we0;
            end else if (win1) begin
                state     <= ACCESS;
                last      <= 1'b1;
                gnt0      <= 1'b0;
                gnt1      <= 1'b1;
                busy      <= 1'b1;
                ram_addr  <= addr1;
                ram_wdata <= wdata1;
                ram_rw    <= we1;
            end else begin
                // Address and data hold; only rw must drop so the RAM sees no stray write.
                state  <= IDLE;
                gnt0   <= 1'b0;
                gnt1   <= 1'b0;
                busy   <= 1'b0;
                ram_rw <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a behavioural 16x8 RAM attached to the RAM port.
module tb_ram_arb2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, ack0, gnt1, ack1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ram_rw, busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_rw) mem[ram_addr] <= ram_wdata;

    ram_arb2 #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rw(ram_rw),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        rst_n = 1;
        clear_inputs();
        #1 rst_n = 0;
        #2;
        ctl = {gnt0, gnt1, ack0, ack1, busy, ram_rw};
        n_cmp++;
        if (ctl !== 6'b0 || ram_addr !== 4'h0 || ram_wdata !== 8'h00 ||
            rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values: ctl=%b addr=%h wdata=%h rd0=%h rd1=%h required all 0",
                     ctl, ram_addr, ram_wdata, rdata0, rdata1);
        end
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            ctl = {gnt0, gnt1, ack0, ack1, busy, ram_rw};
            n_cmp++;
            if (ctl !== 6'b0) begin
                n_err++;
                $display("FAIL idle_after_reset cycle %0d: ctl=%b required 000000", k, ctl);
            end
        end
    endtask

    task automatic test_single_client();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 4'h3; wdata0 = 8'hA5;
        tick();
        n_cmp++;
        if ({gnt0, ack0, gnt1, ack1, busy, ram_rw} !== 6'b100011 || ram_addr !== 4'h3 || ram_wdata !== 8'hA5) begin
            n_err++;
            $display("FAIL c0_write_gnt: g0a0g1a1 busy rw=%b addr=%h wdata=%h required 100011 3 a5",
                     {gnt0, ack0, gnt1, ack1, busy, ram_rw}, ram_addr, ram_wdata);
        end
        tick();
        n_cmp++;
        if ({gnt0, ack0, gnt1, ack1, busy, ram_rw} !== 6'b010000) begin
            n_err++;
            $display("FAIL c0_write_ack: g0a0g1a1 busy rw=%b required 010000", {gnt0, ack0, gnt1, ack1, busy, ram_rw});
        end
        req0 = 0;
        tick();
        req0 = 1; we0 = 0;
        tick();
        n_cmp++;
        if ({gnt0, ack0, gnt1, ack1, ram_rw} !== 5'b10000 || ram_addr !== 4'h3) begin
            n_err++;
            $display("FAIL c0_read_gnt: g0a0g1a1 rw=%b addr=%h required 10000 3",
                     {gnt0, ack0, gnt1, ack1, ram_rw}, ram_addr);
        end
        tick();
        n_cmp++;
        if ({gnt0, ack0, gnt1, ack1} !== 4'b0100 || rdata0 !== 8'hA5) begin
            n_err++;
            $display("FAIL c0_read_ack: g0a0g1a1=%b rdata0=%h required 0100 a5", {gnt0, ack0, gnt1, ack1}, rdata0);
        end
        req0 = 0;
        tick();
    endtask

    task automatic test_single_rate();
        logic [3:0] exp;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 4'h5;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {(k == 1 || k == 3 || k == 5), (k == 2 || k == 4 || k == 6), 2'b00};
            n_cmp++;
            if ({gnt0, ack0, gnt1, ack1} !== exp) begin
                n_err++;
                $display("FAIL single_rate cycle %0d: g0a0g1a1=%b required %b", k, {gnt0, ack0, gnt1, ack1}, exp);
            end
            if (k == 6) req0 = 0;
        end
    endtask

    task automatic test_contention();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 4'h1; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 4'h2; wdata1 = 8'h22;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, ram_rw} !== 3'b101 || ram_addr !== 4'h1 || ram_wdata !== 8'h11) begin
            n_err++;
            $display("FAIL tie_first_c0: g0g1rw=%b addr=%h wdata=%h required 101 1 11", {gnt0, gnt1, ram_rw}, ram_addr, ram_wdata);
        end
        tick();
        n_cmp++;
        if ({ack0, gnt0, gnt1, ack1, ram_rw} !== 5'b10101 || ram_addr !== 4'h2 || ram_wdata !== 8'h22) begin
            n_err++;
            $display("FAIL tie_second_c1: a0g0g1a1rw=%b addr=%h wdata=%h required 10101 2 22",
                     {ack0, gnt0, gnt1, ack1, ram_rw}, ram_addr, ram_wdata);
        end
        req0 = 0;
        tick();
        n_cmp++;
        if ({ack0, gnt0, gnt1, ack1, ram_rw} !== 5'b00010) begin
            n_err++;
            $display("FAIL tie_ack1: a0g0g1a1rw=%b required 00010", {ack0, gnt0, gnt1, ack1, ram_rw});
        end
        req1 = 0;
        tick();
        req0 = 1; we0 = 0; addr0 = 4'h1;
        req1 = 1; we1 = 0; addr1 = 4'h2;
        tick();
        tick();
        n_cmp++;
        if (ack0 !== 1'b1 || rdata0 !== 8'h11) begin
            n_err++;
            $display("FAIL readback_c0: ack0=%b rdata0=%h required 1 11", ack0, rdata0);
        end
        req0 = 0;
        tick();
        n_cmp++;
        if (ack1 !== 1'b1 || rdata1 !== 8'h22) begin
            n_err++;
            $display("FAIL readback_c1: ack1=%b rdata1=%h required 1 22", ack1, rdata1);
        end
        req1 = 0;
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        int         a0_cnt, a1_cnt;
        a0_cnt = 0;
        a1_cnt = 0;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 4'h1;
        req1 = 1; we1 = 0; addr1 = 4'h2;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = {(k <= 16 && k % 2 == 1), (k <= 16 && k % 2 == 0),
                   (k >= 2 && k <= 17 && k % 2 == 0), (k >= 3 && k <= 17 && k % 2 == 1)};
            n_cmp++;
            if ({gnt0, gnt1, ack0, ack1} !== exp) begin
                n_err++;
                $display("FAIL alternation cycle %0d: g0g1a0a1=%b required %b", k, {gnt0, gnt1, ack0, ack1}, exp);
            end
            if (ack0 === 1'b1) a0_cnt++;
            if (ack1 === 1'b1) a1_cnt++;
            if (a0_cnt == 8) req0 = 0;
            if (a1_cnt == 8) req1 = 0;
        end
        n_cmp++;
        if (a0_cnt + a1_cnt !== 16) begin
            n_err++;
            $display("FAIL ack_total: got %0d acks required 16", a0_cnt + a1_cnt);
        end
        req0 = 0;
        req1 = 0;
    endtask

    task automatic test_read_after_write();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 4'hF; wdata0 = 8'h3C;
        req1 = 1; we1 = 0; addr1 = 4'hF;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, ram_rw} !== 3'b101) begin
            n_err++;
            $display("FAIL raw_write_first: g0g1rw=%b required 101", {gnt0, gnt1, ram_rw});
        end
        tick();
        req0 = 0;
        tick();
        n_cmp++;
        if (ack1 !== 1'b1 || rdata1 !== 8'h3C) begin
            n_err++;
            $display("FAIL raw_read_value: ack1=%b rdata1=%h required 1 3c", ack1, rdata1);
        end
        req1 = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        mem[7] = 8'h00;
        req1 = 1; we1 = 1; addr1 = 4'h7; wdata1 = 8'h99;
        tick();
        n_cmp++;
        if ({gnt1, ram_rw} !== 2'b11) begin
            n_err++;
            $display("FAIL mid_write_gnt: g1rw=%b required 11", {gnt1, ram_rw});
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({gnt1, ram_rw, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset_async: g1 rw busy=%b required 000", {gnt1, ram_rw, busy});
        end
        req1 = 0;
        tick();
        n_cmp++;
        if ({ack1, ram_rw} !== 2'b00 || mem[7] !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset_no_commit: ack1 rw=%b mem7=%h required 00 00", {ack1, ram_rw}, mem[7]);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        n_cmp++;
        if (ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_no_ack: ack1=%b required 0", ack1);
        end
        mem[8] = 8'h5A;
        req1 = 1; we1 = 0; addr1 = 4'h8;
        tick();
        tick();
        req1 = 0;
        tick();
        req1 = 1; we1 = 0; addr1 = 4'h7;
        tick();
        tick();
        n_cmp++;
        if (ack1 !== 1'b1 || rdata1 !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset_readback: ack1=%b rdata1=%h required 1 00", ack1, rdata1);
        end
        req1 = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_single_client();
        test_single_rate();
        test_contention();
        test_fairness();
        test_read_after_write();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
